// File: rtl/toggle_pulse_transmitter.sv
// Source side of a toggle-based clock-domain-crossing event link: launches one
// toggle per acknowledge round trip and queues requests that arrive meanwhile.
module toggle_pulse_transmitter #(
    parameter int PENDING_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     send,
    input  logic                     ack_toggle_in,
    output logic                     toggle_out,
    output logic                     busy,
    output logic                     done,
    output logic [PENDING_WIDTH-1:0] pending_count,
    output logic                     overflow
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    localparam logic [PENDING_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [PENDING_WIDTH-1:0] PEND_ONE = {{(PENDING_WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    logic   ack_s1;
    logic   ack_s2;
    logic   ack_match;
    logic   launch_window;
    logic   have_pending;

    // The returned toggle matching ours means the destination has seen the last event.
    assign ack_match     = (ack_s2 == toggle_out);
    assign launch_window = (state == IDLE) || ((state == WAIT_ACK) && ack_match);
    assign have_pending  = (pending_count != '0);
    assign busy          = (state == WAIT_ACK);
    assign done          = enable && (state == WAIT_ACK) && ack_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_out    <= 1'b0;
            ack_s1        <= 1'b0;
            ack_s2        <= 1'b0;
            state         <= IDLE;
            pending_count <= '0;
            overflow      <= 1'b0;
        end else if (enable) begin
            ack_s1 <= ack_toggle_in;
            ack_s2 <= ack_s1;
            if (launch_window) begin
                if (have_pending) begin
                    // A queued request goes out; a coincident send takes its queue slot.
                    toggle_out <= ~toggle_out;
                    state      <= WAIT_ACK;
                    if (!send) begin
                        pending_count <= pending_count - PEND_ONE;
                    end
                end else if (send) begin
                    toggle_out <= ~toggle_out;
                    state      <= WAIT_ACK;
                end else begin
                    state <= IDLE;
                end
            end else if (send) begin
                if (pending_count != PEND_MAX) begin
                    pending_count <= pending_count + PEND_ONE;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_toggle_pulse_transmitter.sv
// Directed bench for toggle_pulse_transmitter: vector table for the basic and
// queueing round trips, hand-written sequences for overflow, gating and reset.
module tb_toggle_pulse_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       send = 1'b0;
    logic       ack_toggle_in = 1'b0;
    logic       toggle_out;
    logic       busy;
    logic       done;
    logic [1:0] pending_count;
    logic       overflow;

    int checks = 0;
    int passes = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       send;
        logic       ack;
        logic       tog;
        logic       busy;
        logic       done;
        logic [1:0] pend;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    toggle_pulse_transmitter #(.PENDING_WIDTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .send          (send),
        .ack_toggle_in (ack_toggle_in),
        .toggle_out    (toggle_out),
        .busy          (busy),
        .done          (done),
        .pending_count (pending_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic s, input logic a,
                                input logic t, input logic b, input logic d,
                                input logic [1:0] p, input logic o);
        vec_t v;
        v.rst = r; v.en = e; v.send = s; v.ack = a;
        v.tog = t; v.busy = b; v.done = d; v.pend = p; v.ovf = o;
        return v;
    endfunction

    // Inputs change 1 time unit after an edge, outputs are sampled at the same point.
    task automatic applyStimulus(input logic r, input logic e, input logic s, input logic a);
        rst = r;
        enable = e;
        send = s;
        ack_toggle_in = a;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic t, input logic b, input logic d,
                               input logic [1:0] p, input logic o);
        logic [5:0] act;
        logic [5:0] req;
        act = {toggle_out, busy, done, pending_count, overflow};
        req = {t, b, d, p, o};
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            failures++;
            $display("[TB] FAIL %s: got tog/busy/done/pend/ovf=%b/%b/%b/%0d/%b, want %b/%b/%b/%0d/%b",
                     name, act[5], act[4], act[3], act[2:1], act[0],
                     req[5], req[4], req[3], req[2:1], req[0]);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int req);
        checks++;
        if (act == req) begin
            passes++;
        end else begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    initial begin
        int   edges;
        int   dones;
        logic prev_tog;

        // Single event then three queued events, fields: rst en send ack | tog busy done pend ovf
        vecs.push_back(mk(1, 1, 0, 0,  0, 0, 0, 2'd0, 0));
        vecs.push_back(mk(0, 1, 1, 0,  1, 1, 0, 2'd0, 0));
        vecs.push_back(mk(0, 1, 0, 1,  1, 1, 0, 2'd0, 0));
        vecs.push_back(mk(0, 1, 0, 1,  1, 1, 1, 2'd0, 0));
        vecs.push_back(mk(0, 1, 0, 1,  1, 0, 0, 2'd0, 0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0, 0, 2'd0, 0));
        vecs.push_back(mk(0, 1, 1, 0,  1, 1, 0, 2'd0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  1, 1, 0, 2'd0, 0));
        vecs.push_back(mk(0, 1, 1, 0,  1, 1, 0, 2'd1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  1, 1, 0, 2'd1, 0));
        vecs.push_back(mk(0, 1, 1, 0,  1, 1, 0, 2'd2, 0));
        vecs.push_back(mk(0, 1, 0, 1,  1, 1, 0, 2'd2, 0));
        vecs.push_back(mk(0, 1, 0, 1,  1, 1, 1, 2'd2, 0));
        vecs.push_back(mk(0, 1, 0, 1,  0, 1, 0, 2'd1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 1, 0, 2'd1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 1, 1, 2'd1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  1, 1, 0, 2'd0, 0));
        vecs.push_back(mk(0, 1, 0, 1,  1, 1, 0, 2'd0, 0));
        vecs.push_back(mk(0, 1, 0, 1,  1, 1, 1, 2'd0, 0));
        vecs.push_back(mk(0, 1, 0, 1,  1, 0, 0, 2'd0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].send, vecs[i].ack);
            checkOutput($sformatf("vec%0d", i), vecs[i].tog, vecs[i].busy, vecs[i].done,
                        vecs[i].pend, vecs[i].ovf);
        end

        // Overflow: five requests while waiting saturate the queue at 3
        applyStimulus(1, 1, 0, 0);
        edges = 0;
        dones = 0;
        prev_tog = toggle_out;
        applyStimulus(0, 1, 1, 0);
        if (toggle_out != prev_tog) edges++;
        prev_tog = toggle_out;
        checkOutput("ovf_launch", 1, 1, 0, 2'd0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 1, 0);
            checkOutput($sformatf("ovf_pulse%0d", i), 1, 1, 0,
                        (i >= 2) ? 2'd3 : 2'(i + 1), (i >= 3) ? 1'b1 : 1'b0);
            applyStimulus(0, 1, 0, 0);
        end
        // The bench acts as the destination, echoing every toggle back
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            applyStimulus(0, 1, 0, toggle_out);
            if (toggle_out != prev_tog) edges++;
            prev_tog = toggle_out;
        end
        checkCount("ovf_toggle_edges", edges, 4);
        checkCount("ovf_done_pulses", dones, 4);
        checkOutput("ovf_drained", toggle_out, 0, 0, 2'd0, 1);
        checkCount("ovf_final_toggle", int'(toggle_out), 0);

        // Send coinciding with acknowledge while one request is queued
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 1);
        checkOutput("sim_ack_seen", 1, 1, 1, 2'd1, 0);
        applyStimulus(0, 1, 1, 1);
        checkOutput("sim_relaunch", 0, 1, 0, 2'd1, 0);

        // Enable low freezes everything including the ack synchronizer
        applyStimulus(0, 0, 1, 0);
        checkOutput("gate0", 0, 1, 0, 2'd1, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("gate1", 0, 1, 0, 2'd1, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("gate2", 0, 1, 0, 2'd1, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("gate_en1", 0, 1, 0, 2'd1, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("gate_en2", 0, 1, 1, 2'd1, 0);

        // Reset mid-flight with two queued and overflow set; rst beats enable low and send
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 0);
            applyStimulus(0, 1, 0, 0);
        end
        checkOutput("rst_full", 1, 1, 0, 2'd3, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 1);
        checkOutput("rst_pre", 0, 1, 0, 2'd2, 1);
        applyStimulus(1, 0, 1, 1);
        checkOutput("rst_mid", 0, 0, 0, 2'd0, 0);
        applyStimulus(0, 1, 1, 0);
        checkOutput("rst_after_send", 1, 1, 0, 2'd0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
